// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_pkg
//  Description : Shared constants and types for the Viterbi decoder stages
//                (K=3, radix-4 trellis): state/address widths, survivor
//                memory geometry and the traceback state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    // Trellis geometry
    localparam int NUM_STATES = 4;
    localparam int S_W        = 2;
    localparam int DEPTH      = 12;
    localparam int ADDR_W     = 4;

    // Derived widths
    localparam int MEM_W      = NUM_STATES * 2;   // one predecessor field per state
    localparam int DEC_W      = 2 * DEPTH;        // two decoded bits per step

    // Traceback controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_TRACE = 3'd2,
        ST_DONE  = 3'd3,
        ST_WAIT  = 3'd4
    } tbk_state_e;

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/viterbi_traceback_if.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_traceback_if
//  Description : Bundle between the traceback unit, the decoder control and
//                the survivor memory.
//                  en_traceback - traceback request (rising edge starts)
//                  best_state   - minimum-metric final state
//                  mem_rdata    - survivor word, one predecessor per state
//                  mem_ren      - survivor memory read enable
//                  mem_raddr    - survivor memory read address
//                  dec_data     - decoded block, step j at [2j+1:2j]
//                  dec_valid    - one-cycle completion pulse
//                  busy         - traceback in progress
//                master: control/memory side, slave: traceback unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface viterbi_traceback_if;
    import viterbi_pkg::*;

    logic              en_traceback;
    logic [S_W-1:0]    best_state;
    logic [MEM_W-1:0]  mem_rdata;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DEC_W-1:0]  dec_data;
    logic              dec_valid;
    logic              busy;

    modport master (
        output en_traceback,
        output best_state,
        output mem_rdata,
        input  mem_ren,
        input  mem_raddr,
        input  dec_data,
        input  dec_valid,
        input  busy
    );

    modport slave (
        input  en_traceback,
        input  best_state,
        input  mem_rdata,
        output mem_ren,
        output mem_raddr,
        output dec_data,
        output dec_valid,
        output busy
    );

endinterface : viterbi_traceback_if
`default_nettype wire

// File: rtl/viterbi_traceback.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_traceback
//  Description : Radix-4 traceback unit for a K=3 Viterbi decoder. Starting
//                from the best final state it walks the survivor memory from
//                the newest step (DEPTH-1) down to step 0, emitting the
//                current state as the two decoded bits of each step, then
//                pulses dec_valid for one cycle with the complete block.
//  Ports       : clk  - clock
//                rst  - asynchronous active-low reset
//                vif  - viterbi_traceback_if.slave (request, survivor
//                       memory read port, decoded output, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module viterbi_traceback
    import viterbi_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    viterbi_traceback_if.slave  vif
);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    tbk_state_e        state_q, state_d;
    logic              en_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [S_W-1:0]    cur_q, cur_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic              dec_valid_q;

    // Combinational helpers
    logic              w_start;
    logic              w_ptr_zero;
    logic [S_W-1:0]    w_pred;
    logic              w_mem_ren;
    logic [ADDR_W-1:0] w_mem_raddr;
    logic              w_busy;

    assign w_start    = vif.en_traceback & ~en_q;
    assign w_ptr_zero = (ptr_q == '0);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // Dropping the request while fetching or tracing abandons the walk; once
    // DONE is reached the result is committed regardless of the request.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!vif.en_traceback) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TRACE;
                end
            end
            ST_TRACE: begin
                if (!vif.en_traceback) begin
                    state_d = ST_IDLE;
                end else if (w_ptr_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Holding the request high parks here: no retrace.
                if (!vif.en_traceback) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // The read address depends only on ptr, never on cur, so while tracing
    // step ptr the read for step ptr-1 is already issued. This keeps one
    // survivor read per cycle back-to-back.
    // ------------------------------------------------------------------------
    always_comb begin
        w_mem_ren   = 1'b0;
        w_mem_raddr = '0;
        w_busy      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                w_mem_ren   = 1'b1;
                w_mem_raddr = ptr_q;
                w_busy      = 1'b1;
            end
            ST_TRACE: begin
                w_busy = 1'b1;
                if (!w_ptr_zero) begin
                    w_mem_ren   = 1'b1;
                    w_mem_raddr = ptr_q - ADDR_W'(1);
                end
            end
            ST_DONE: begin
                w_busy = 1'b1;
            end
            default: begin
                w_mem_ren   = 1'b0;
                w_mem_raddr = '0;
                w_busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Predecessor select: field cur of the survivor word
    // ------------------------------------------------------------------------
    always_comb begin
        w_pred = '0;
        for (int s = 0; s < NUM_STATES; s++) begin
            if (cur_q == S_W'(s)) begin
                w_pred = vif.mem_rdata[2*s +: S_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // After a radix-4 step the state equals that step's two input bits, so
    // the decoded bits of step ptr are simply cur.
    // ------------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        cur_d = cur_q;
        dec_d = dec_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    ptr_d = ADDR_W'(DEPTH - 1);
                    cur_d = vif.best_state;
                end
            end
            ST_TRACE: begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (ptr_q == ADDR_W'(j)) begin
                        dec_d[2*j +: S_W] = cur_q;
                    end
                end
                cur_d = w_pred;
                // Step 0 is the last one processed; ptr never wraps.
                if (!w_ptr_zero) begin
                    ptr_d = ptr_q - ADDR_W'(1);
                end
            end
            default: begin
                ptr_d = ptr_q;
                cur_d = cur_q;
                dec_d = dec_q;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // dec_valid is registered off DONE so it rises on the edge after DONE is
    // entered and lasts exactly one cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            ptr_q       <= '0;
            cur_q       <= '0;
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            en_q        <= vif.en_traceback;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            dec_q       <= dec_d;
            dec_valid_q <= (state_q == ST_DONE);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vif.mem_ren   = w_mem_ren;
    assign vif.mem_raddr = w_mem_raddr;
    assign vif.busy      = w_busy;
    assign vif.dec_data  = dec_q;
    assign vif.dec_valid = dec_valid_q;

endmodule : viterbi_traceback
`default_nettype wire

// File: tb/tb_viterbi_traceback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_viterbi_traceback
//  Description : Self-checking bench for viterbi_traceback. A timeline model
//                (cycles since the start edge) predicts busy / read port /
//                dec_valid every cycle, and a direct walk of the survivor
//                array predicts the decoded block. Directed traces carry
//                hand-computed literal results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_traceback;
    import viterbi_pkg::*;

    logic clk;
    logic rst;

    viterbi_traceback_if bus ();

    viterbi_traceback dut (
        .clk (clk),
        .rst (rst),
        .vif (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Survivor memory: synchronous read, data the cycle after the address
    // ------------------------------------------------------------------------
    logic [MEM_W-1:0] mem [0:15];

    always @(posedge clk) begin
        if (bus.mem_ren) begin
            bus.mem_rdata <= mem[bus.mem_raddr];
        end
    end

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;
    int n_pulses = 0;
    int n_reads  = 0;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (bus.dec_valid) n_pulses++;
        if (bus.mem_ren)   n_reads++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Walk the survivor array from step DEPTH-1 down to 0.
    function automatic logic [DEC_W-1:0] trace_model(input logic [S_W-1:0] best);
        logic [DEC_W-1:0] r;
        logic [S_W-1:0]   s;
        logic [MEM_W-1:0] w;
        r = '0;
        s = best;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            r[2*j +: 2] = s;
            w = mem[j];
            s = w[2*s +: 2];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Timeline model. m_k counts edges since the start edge E0:
    //   k=0 fetch, k=1..DEPTH tracing, k=DEPTH+1 done, k>=DEPTH+2 waiting.
    // ------------------------------------------------------------------------
    bit               m_active    = 1'b0;
    int               m_k         = 0;
    bit               m_prev_en   = 1'b0;
    bit               m_dec_known = 1'b1;
    logic [DEC_W-1:0] m_dec       = '0;
    logic [DEC_W-1:0] m_exp       = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active    = 1'b0;
            m_k         = 0;
            m_prev_en   = 1'b0;
            m_dec_known = 1'b1;
            m_dec       = '0;
        end else begin
            if (m_active) begin
                if (m_k <= DEPTH && !bus.en_traceback) begin
                    m_active    = 1'b0;      // aborted: partial result undefined
                    m_dec_known = 1'b0;
                end else if (m_k >= DEPTH + 2 && !bus.en_traceback) begin
                    m_active = 1'b0;         // released from waiting, result kept
                end else begin
                    m_k++;
                end
            end else if (bus.en_traceback && !m_prev_en) begin
                m_active    = 1'b1;
                m_k         = 0;
                m_dec_known = 1'b0;
                m_exp       = trace_model(bus.best_state);
            end
            if (m_active && m_k == DEPTH + 2) begin
                m_dec_known = 1'b1;
                m_dec       = m_exp;
            end
            m_prev_en = bus.en_traceback;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        bit e_busy, e_ren, e_valid;
        e_busy  = m_active && (m_k <= DEPTH + 1);
        e_ren   = m_active && (m_k <= DEPTH - 1);
        e_valid = m_active && (m_k == DEPTH + 2);
        chk("busy",      32'(bus.busy),      32'(e_busy));
        chk("mem_ren",   32'(bus.mem_ren),   32'(e_ren));
        chk("dec_valid", 32'(bus.dec_valid), 32'(e_valid));
        if (e_ren) begin
            chk("mem_raddr", 32'(bus.mem_raddr), 32'(DEPTH - 1 - m_k));
        end else if (!m_active || m_k >= DEPTH + 1) begin
            chk("mem_raddr_idle", 32'(bus.mem_raddr), 32'd0);
        end
        if (m_dec_known) begin
            chk("dec_data", 32'(bus.dec_data), 32'(m_dec));
        end
    end

    // ------------------------------------------------------------------------
    // One complete traceback with hand-computed expected block.
    // ------------------------------------------------------------------------
    task automatic run_trace(input logic [S_W-1:0] best, input logic [MEM_W-1:0] w_even,
                             input logic [MEM_W-1:0] w_odd, input logic [DEC_W-1:0] lit,
                             input int hold, input string name);
        int t0, t1, p0, r0;
        bit got;
        for (int j = 0; j < DEPTH; j++) mem[j] = (j % 2 == 0) ? w_even : w_odd;
        chk({name, "_model"}, 32'(trace_model(best)), 32'(lit));
        bus.best_state = best;
        p0 = n_pulses;
        r0 = n_reads;
        @(posedge clk); #1;
        bus.en_traceback = 1'b1;
        t0 = edge_cnt;
        @(posedge clk); #1;                 // E0 has sampled start
        bus.best_state = ~best;             // must be ignored from here on
        got = 1'b0;
        t1  = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.dec_valid) begin
                got = 1'b1;
                t1  = edge_cnt;
            end
        end
        chk({name, "_valid_seen"}, 32'(got), 32'd1);
        if (got) begin
            // raise after edge t0, E0 = t0+1, pulse after E14 = t0+15
            chk({name, "_latency"}, 32'(t1 - t0), 32'd15);
            chk({name, "_dec"},     32'(bus.dec_data), 32'(lit));
        end
        repeat (hold) @(posedge clk);
        #1;
        chk({name, "_busy_wait"}, 32'(bus.busy), 32'd0);
        bus.en_traceback = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_pulses"}, 32'(n_pulses - p0), 32'd1);
        chk({name, "_reads"},  32'(n_reads - r0),  32'd12);
        chk({name, "_dec_kept"}, 32'(bus.dec_data), 32'(lit));
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int p0;
        bus.en_traceback = 1'b0;
        bus.best_state   = '0;
        for (int j = 0; j < 16; j++) mem[j] = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dec",   32'(bus.dec_data),  32'd0);
        chk("reset_valid", 32'(bus.dec_valid), 32'd0);
        chk("reset_busy",  32'(bus.busy),      32'd0);
        chk("reset_ren",   32'(bus.mem_ren),   32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // pred(s)=0 everywhere: only the newest step carries best_state
        run_trace(2'b11, 8'h00, 8'h00, 24'hC00000, 2, "zero");
        // pred(s)=s: best_state repeats in every step
        run_trace(2'b10, 8'hE4, 8'hE4, 24'hAAAAAA, 2, "ident");
        // pred(s)=3-s: alternates 01/10 from best=01
        run_trace(2'b01, 8'h1B, 8'h1B, 24'h666666, 2, "swap");

        // Abort after 5 tracing cycles
        for (int j = 0; j < DEPTH; j++) mem[j] = 8'h1B;
        bus.best_state = 2'b01;
        p0 = n_pulses;
        @(posedge clk); #1;
        bus.en_traceback = 1'b1;
        repeat (7) @(posedge clk);          // E0 fetch, E1..E6 tracing
        #1;
        bus.en_traceback = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_pulses", 32'(n_pulses - p0), 32'd0);
        chk("abort_busy",   32'(bus.busy),      32'd0);
        run_trace(2'b11, 8'h1B, 8'h1B, 24'hCCCCCC, 2, "restart");

        // Hold the request high long after completion
        run_trace(2'b10, 8'hE4, 8'hE4, 24'hAAAAAA, 50, "hold");

        // Reset mid-trace
        mem[0] = 8'h00;
        bus.best_state = 2'b01;
        @(posedge clk); #1;
        bus.en_traceback = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        bus.en_traceback = 1'b0;
        @(negedge clk);
        chk("midrst_busy",  32'(bus.busy),      32'd0);
        chk("midrst_ren",   32'(bus.mem_ren),   32'd0);
        chk("midrst_raddr", 32'(bus.mem_raddr), 32'd0);
        chk("midrst_valid", 32'(bus.dec_valid), 32'd0);
        chk("midrst_dec",   32'(bus.dec_data),  32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_idle", 32'(bus.busy), 32'd0);

        // Non-uniform memory: odd steps swap, even steps identity
        run_trace(2'b00, 8'hE4, 8'h1B, 24'h3C3C3C, 2, "mixed");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_viterbi_traceback
`default_nettype wire

// File: doc/viterbi_traceback.md
# viterbi_traceback

Radix-4 traceback unit of the Viterbi decoder, directly downstream of the decoder control FSM and the survivor memory. When the controller raises `en_traceback`, the block starts from the best final state and walks the survivor memory from the newest trellis step to the oldest. It recovers two decoded bits per step and presents the full decoded block with a one-cycle valid pulse. It targets K=3 (4 states). After one radix-4 step the state equals the two input bits of that step, so the decoded bits of a step are the current state.

## Interface
Parameters:
- `NUM_STATES`, 4: trellis states; state width `S_W` = 2.
- `DEPTH`, 12: radix-4 steps held in survivor memory.
- `ADDR_W`, 4: survivor memory address width, ≥ clog2(DEPTH).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en_traceback`  in  1  from control. Traceback starts on its rising edge. The controller holds it high afterwards.
- `best_state`  in  S_W  state with minimum path metric. Sampled at start.
- `mem_rdata`  in  NUM_STATES*2  survivor word. Bits [2s+1:2s] hold the predecessor of state s. Synchronous read, valid the cycle after the address.
- `mem_ren`  out  1  read enable.
- `mem_raddr`  out  ADDR_W  read address.
- `dec_data`  out  2*DEPTH  decoded bits. Step j occupies bits [2j+1:2j]; bit 2j+1 is the older bit.
- `dec_valid`  out  1  one-cycle pulse when `dec_data` is complete.
- `busy`  out  1  high in FETCH, TRACE, DONE.

## Operation
Internal registers:
- `en_d`: previous value of `en_traceback`.
- `start` = `en_traceback` & ~`en_d`.
- `ptr`: step counter, ADDR_W bits.
- `cur`: current state, S_W bits.

State machine:
- IDLE: `mem_ren`=0. On `start`, load `ptr`←DEPTH-1 and `cur`←`best_state`, then go to FETCH.
- FETCH: `mem_ren`=1, `mem_raddr`=`ptr`. Next state is TRACE.
- TRACE: `mem_rdata` belongs to step `ptr`.
  - Write `dec_data[2*ptr+1:2*ptr]` ← `cur`.
  - Update `cur` ← `mem_rdata[2*cur+1:2*cur]`.
  - If `ptr`≠0: `mem_ren`=1, `mem_raddr`=`ptr`-1, and `ptr` decrements. The next read is prefetched because the address does not depend on `cur`.
  - If `ptr`=0: `mem_ren`=0, go to DONE.
- DONE: `dec_valid`=1. Next state is WAIT.
- WAIT: `dec_data` is held. Return to IDLE when `en_traceback`=0.

`mem_raddr` and `mem_ren` are combinational from state and `ptr`. In IDLE, WAIT and DONE, `mem_raddr` = 0.

Boundary conditions:
- `en_traceback` low in FETCH or TRACE: abort to IDLE next edge. No `dec_valid`. Partially written `dec_data` is retained but meaningless. A new rising edge is required to restart.
- `en_traceback` held high after DONE: stay in WAIT. There is no retrace.
- `best_state` changes after start: ignored.
- Reset mid-trace: immediate return to IDLE with all registers cleared.
- `ptr` never wraps; the last step processed is step 0.

## Timing
- Reset values: `dec_data`=0, `dec_valid`=0, `busy`=0, `mem_ren`=0, `mem_raddr`=0, `en_d`=0, state IDLE.
- Let E0 be the edge that samples `start`=1.
- FETCH runs during cycle E0–E1.
- TRACE covers `ptr`=DEPTH-1…0 on edges E2…E(DEPTH+1).
- `dec_valid` is high for exactly one cycle starting at edge E(DEPTH+2). That is 14 edges after start for DEPTH=12.
- Memory is read once per step, DEPTH reads total, one per cycle back-to-back.

## Structure
- `viterbi_pkg` holds `NUM_STATES`, `S_W`, `DEPTH`, `ADDR_W`, and the traceback state enum (IDLE, FETCH, TRACE, DONE, WAIT). All decoder stages share it.
- The block is a single module. The predecessor select (4:1 mux of 2-bit fields indexed by `cur`) stays inline, and no sub-module is warranted.

## Test plan
- Reset check: drive `rst`=0 mid-TRACE → all outputs 0 and state IDLE on the next cycle. After release, the block waits for a fresh rising edge.
- Zero predecessors: every `mem_rdata`=8'h00, `best_state`=2'b11 → `dec_data`=24'hC00000. `dec_valid` pulses once, 14 edges after start.
- Identity predecessors: every `mem_rdata`=8'hE4, `best_state`=2'b10 → `dec_data`=24'hAAAAAA.
- Read sequence: `mem_raddr` = 11,10,…,0 on consecutive cycles with `mem_ren`=1 for exactly 12 cycles.
- Abort: drop `en_traceback` after 5 TRACE cycles → no `dec_valid`. Raising it again starts a fresh traceback with the correct result.
- Hold: keep `en_traceback` high for 50 cycles after DONE → exactly one `dec_valid` pulse, `dec_data` stable, `busy`=0.
